// File: rtl/spi_master.sv
// spi_master: SPI bus initiator with a per-transfer CPOL/CPHA mode.
// A host word is shifted out on mosi while miso is captured. The received
// word is returned on rx_data together with a one-cycle done pulse.
//
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN
//   When defined, a lsb_first input selects LSB-first ordering per transfer.
//   When undefined, the port is absent and transfers are always MSB first.
//
// Ports:
//   clk, reset       system clock and synchronous active-high reset
//   start            transfer request, honoured only while busy=0
//   tx_data          word to send, latched on an accepted start
//   cpol, cpha       SPI mode, latched on an accepted start
//   lsb_first        bit order, latched on an accepted start (optional)
//   miso             serial data from the slave, no synchroniser
//   sclk, mosi, cs_n serial bus outputs
//   busy             a transfer is in progress
//   done             one-cycle pulse at the end of a transfer
//   rx_data          last received word, held between done pulses
//
// Transfer timeline, with the start accepted at cycle 0:
//   cycle 1                    cs_n low, busy high, SETUP begins
//   cycle 1 + k*CLK_DIV        SCLK edge k, for k = 1..2*DATA_W
//   cycle 1 + (2*DATA_W+1)*CLK_DIV   cs_n high, done pulse, back in IDLE

module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  // ---------------------------------------------------------------------
  // Counter sizing
  // ---------------------------------------------------------------------
  // The divider width depends only on CLK_DIV. It carries one spare bit so
  // that CLK_DIV=1 still gets a legal one-bit counter.
  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(2 * DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // ---------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              cpha_q;
  logic              lsb_q;
  logic              lsb_in;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              sclk_q;
  logic              mosi_q;
  logic              done_q;
  logic [DATA_W-1:0] rx_q;

  // Next values, produced by the output process.
  logic [DATA_W-1:0] tx_sh_nx;
  logic [DATA_W-1:0] rx_sh_nx;
  logic              sclk_nx;
  logic              mosi_nx;
  logic              done_nx;
  logic [DATA_W-1:0] rx_nx;

  // Per-cycle event decode.
  logic accept;
  logic tick;
  logic edge_ev;
  logic leading;
  logic last_edge;
  logic sample_ev;
  logic drive_ev;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Bit-order helpers
  // ---------------------------------------------------------------------
  function automatic logic first_bit(input logic [DATA_W-1:0] w,
                                     input logic              lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w,
                                                  input logic              lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // MSB-first fills from bit 0 upward, so the first sample ends up in the
  // MSB after DATA_W samples. LSB-first is the mirror image of this.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic              lsb,
                                                 input logic              b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // ---------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------
  assign accept    = (state == IDLE) && start;
  assign tick      = (div_cnt == DIV_LAST);
  // SCLK edge 1 falls on the last SETUP cycle. Edges 2..2*DATA_W fall on
  // XFER ticks. bit_cnt holds the index (0-based) of the next edge.
  assign edge_ev   = tick && ((state == SETUP) || (state == XFER));
  assign leading   = ~bit_cnt[0];
  assign last_edge = (bit_cnt == BIT_LAST);
  // cpha=0 samples on leading edges. cpha=1 samples on trailing edges.
  assign sample_ev = edge_ev && (leading ^ cpha_q);
  // cpha=0 has its first bit already on mosi, so it drives on trailing
  // edges, except the final one. cpha=1 drives on every leading edge.
  assign drive_ev  = edge_ev && (cpha_q ? leading : (~leading && ~last_edge));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start)             state_nx = SETUP;
      SETUP: if (tick)              state_nx = XFER;
      XFER:  if (tick && last_edge) state_nx = HOLD;
      HOLD:  if (tick)              state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------
  // cs_n and busy decode straight from the state register. The serial
  // outputs, done and rx_data are registered from the next values below.
  always_comb begin
    sclk_nx  = sclk_q;
    mosi_nx  = mosi_q;
    done_nx  = 1'b0;
    rx_nx    = rx_q;
    tx_sh_nx = tx_sh;
    rx_sh_nx = rx_sh;

    unique case (state)
      IDLE: begin
        // While idle, sclk tracks the live cpol input. That way the first
        // SETUP cycle already sits at the idle level latched for this word.
        sclk_nx = cpol;
        mosi_nx = 1'b0;
        if (start) begin
          rx_sh_nx = '0;
          if (cpha) begin
            tx_sh_nx = tx_data;
          end else begin
            mosi_nx  = first_bit(tx_data, lsb_in);
            tx_sh_nx = shift_out(tx_data, lsb_in);
          end
        end
      end

      SETUP, XFER: begin
        if (edge_ev) begin
          sclk_nx = ~sclk_q;
        end
        if (sample_ev) begin
          rx_sh_nx = shift_in(rx_sh, lsb_q, miso);
        end
        if (drive_ev) begin
          mosi_nx  = first_bit(tx_sh, lsb_q);
          tx_sh_nx = shift_out(tx_sh, lsb_q);
        end
      end

      HOLD: begin
        // sclk is already back at its idle level after an even edge count.
        // mosi keeps the last bit until exit.
        if (tick) begin
          done_nx = 1'b1;
          rx_nx   = rx_sh;
          mosi_nx = 1'b0;
        end
      end

      default: begin
        mosi_nx = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      cpha_q  <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
    end else begin
      // The divider free-runs during a transfer. Every phase lasts a
      // whole number of CLK_DIV periods, so it never needs a reload.
      if (state == IDLE) begin
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (accept) begin
        bit_cnt <= '0;
        cpha_q  <= cpha;
      end else if (edge_ev) begin
        bit_cnt <= last_edge ? '0 : bit_cnt + BIT_W'(1);
      end

      tx_sh  <= tx_sh_nx;
      rx_sh  <= rx_sh_nx;
      sclk_q <= sclk_nx;
      mosi_q <= mosi_nx;
      done_q <= done_nx;
      rx_q   <= rx_nx;
    end
  end

`ifdef SPI_MASTER_LSB_FIRST_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lsb_q <= 1'b0;
    end else if (accept) begin
      lsb_q <= lsb_first;
    end
  end
`endif

  assign cs_n    = (state == IDLE);
  assign busy    = (state != IDLE);
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign done    = done_q;
  assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master. Instance u0 uses the default parameters
// (8 bits, CLK_DIV=4). Instance u1 uses CLK_DIV=1 for back-to-back transfers.
// Cycle numbering: cycle 0 is the cycle in which start is high and accepted.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // u0: default parameters
  logic       start0, cpol0, cpha0, miso0, sclk0, mosi0, cs_n0, busy0, done0;
  logic [7:0] tx0, rx0;
  logic       loop0;
  logic       slv_out;
  assign miso0 = loop0 ? mosi0 : slv_out;

  // u1: CLK_DIV=1, permanent loopback
  logic       start1, miso1, sclk1, mosi1, cs_n1, busy1, done1;
  logic [7:0] tx1, rx1;
  assign miso1 = mosi1;

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb0, lsb1;
`endif

  spi_master #(.DATA_W(8), .CLK_DIV(4)) u0 (
    .clk(clk), .reset(reset), .start(start0), .tx_data(tx0),
    .cpol(cpol0), .cpha(cpha0),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb0),
`endif
    .miso(miso0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0),
    .busy(busy0), .done(done0), .rx_data(rx0)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
    .cpol(1'b0), .cpha(1'b0),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb1),
`endif
    .miso(miso1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1),
    .busy(busy1), .done(done1), .rx_data(rx1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Monitors: sclk rising edges under cs_n, and done pulses of u0.
  int rise0 = 0;
  int done_cnt0 = 0;
  always @(posedge sclk0) if (cs_n0 === 1'b0) rise0++;
  always @(posedge clk)   if (done0 === 1'b1) done_cnt0++;

  // Mode-3 slave: it drives miso on falling (leading) edges and captures
  // mosi on rising (trailing) edges. The index restarts whenever cs_n rises.
  logic [7:0] slv_word;
  logic [7:0] slv_rx = 8'h00;
  int         slv_idx = 0;
  always @(negedge sclk0 or posedge cs_n0) begin
    if (cs_n0 === 1'b1) begin
      slv_idx = 0;
    end else if (slv_idx < 8) begin
      slv_out = slv_word[7 - slv_idx];
      slv_idx++;
    end
  end
  always @(posedge sclk0) if (cs_n0 === 1'b0) slv_rx = {slv_rx[6:0], mosi0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Starts a u0 transfer and returns the cycle in which done is seen.
  // -1 means no done within the budget. Optionally pulses start with 0xFF
  // at cycle inj_cyc while the transfer is running.
  task automatic run0(input int inj_cyc, output int dcyc);
    dcyc   = -1;
    cyc    = 0;
    start0 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cyc == 1) start0 = 1'b0;
      if (inj_cyc > 0 && cyc == inj_cyc) begin
        start0 = 1'b1;
        tx0    = 8'hFF;
      end
      if (inj_cyc > 0 && cyc == inj_cyc + 1) start0 = 1'b0;
      if (done0 === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   d, d1, d2;
    logic pre_csn, mid_csn, post_csn;
    logic [7:0] r1, r2;
    logic m1, m5, m10;

    reset    = 1'b1;
    start0   = 1'b0; tx0 = 8'h00; cpol0 = 1'b0; cpha0 = 1'b0; loop0 = 1'b1;
    start1   = 1'b0; tx1 = 8'h00;
    slv_word = 8'h00;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb0 = 1'b0; lsb1 = 1'b0;
`endif

    // ---- reset state
    repeat (3) tick();
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_cs_n", cs_n0, 1'b1);
    chk("rst_mosi", mosi0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_rx",   rx0,   8'h00);
    chk("rst_cs_n1", cs_n1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_sclk1", sclk1, 1'b0);
    reset = 1'b0;
    repeat (2) tick();

    // ---- mode 0 loopback, 0xA5
    tx0 = 8'hA5; rise0 = 0; done_cnt0 = 0;
    chk("m0_idle_sclk", sclk0, 1'b0);
    run0(0, d);
    chk("m0_done_cycle", d, 69);
    chk("m0_rx", rx0, 8'hA5);
    chk("m0_cs_n_at_done", cs_n0, 1'b1);
    chk("m0_busy_at_done", busy0, 1'b0);
    chk("m0_sclk_rises", rise0, 8);
    tick();
    chk("m0_done_one_cycle", done0, 1'b0);
    chk("m0_done_count", done_cnt0, 1);
    chk("m0_idle_sclk_after", sclk0, 1'b0);

    // ---- start while busy is ignored
    tx0 = 8'hA5; done_cnt0 = 0;
    run0(10, d);
    chk("ign_done_cycle", d, 69);
    chk("ign_rx", rx0, 8'hA5);
    repeat (20) tick();
    chk("ign_done_count", done_cnt0, 1);
    chk("ign_busy_after", busy0, 1'b0);

    // ---- reset at cycle 30 of a transfer
    done_cnt0 = 0; tx0 = 8'h3C; start0 = 1'b1; cyc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cyc == 1) start0 = 1'b0;
    end
    chk("rab_busy_c30", busy0, 1'b1);
    reset = 1'b1;
    tick();
    chk("rab_cs_n", cs_n0, 1'b1);
    chk("rab_sclk", sclk0, 1'b0);
    chk("rab_busy", busy0, 1'b0);
    chk("rab_rx",   rx0,   8'h00);
    reset = 1'b0;
    repeat (80) tick();
    chk("rab_no_done", done_cnt0, 0);
    tx0 = 8'h5A;
    run0(0, d);
    chk("rab_new_done_cycle", d, 69);
    chk("rab_new_rx", rx0, 8'h5A);

    // ---- mode 3 against the slave model
    cpol0 = 1'b1; cpha0 = 1'b1; loop0 = 1'b0;
    slv_word = 8'h3C; tx0 = 8'hC3;
    repeat (3) tick();
    chk("m3_idle_sclk_pre", sclk0, 1'b1);
    run0(0, d);
    chk("m3_done_cycle", d, 69);
    chk("m3_rx", rx0, 8'h3C);
    chk("m3_slave_rx", slv_rx, 8'hC3);
    tick();
    chk("m3_idle_sclk_post", sclk0, 1'b1);
    cpol0 = 1'b0; cpha0 = 1'b0; loop0 = 1'b1;
    repeat (3) tick();

    // ---- CLK_DIV=1, back-to-back 0x01 then 0x80
    d1 = -1; d2 = -1; r1 = 8'h00; r2 = 8'h00;
    pre_csn = 1'bx; mid_csn = 1'bx; post_csn = 1'bx;
    tx1 = 8'h01; start1 = 1'b1; cyc = 0;
    for (int i = 0; i < 100; i++) begin
      logic prev;
      prev = cs_n1;
      tick();
      if (cyc == 1) start1 = 1'b0;
      if (d1 > 0 && cyc == d1 + 1) begin
        start1   = 1'b0;
        post_csn = cs_n1;
      end
      if (done1 === 1'b1) begin
        if (d1 < 0) begin
          d1 = cyc; r1 = rx1; pre_csn = prev; mid_csn = cs_n1;
          start1 = 1'b1; tx1 = 8'h80;
        end else begin
          d2 = cyc; r2 = rx1;
          break;
        end
      end
    end
    chk("b2b_first_len", d1, 18);
    chk("b2b_first_rx", r1, 8'h01);
    chk("b2b_cs_n_before", pre_csn, 1'b0);
    chk("b2b_cs_n_gap", mid_csn, 1'b1);
    chk("b2b_cs_n_after", post_csn, 1'b0);
    chk("b2b_second_len", d2 - d1, 18);
    chk("b2b_second_rx", r2, 8'h80);

`ifdef SPI_MASTER_LSB_FIRST_EN
    // ---- LSB first, 0x01 in loopback
    repeat (3) tick();
    lsb0 = 1'b1; tx0 = 8'h01; start0 = 1'b1; cyc = 0;
    m1 = 1'bx; m5 = 1'bx; m10 = 1'bx; d = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (cyc == 1)  begin start0 = 1'b0; m1 = mosi0; end
      if (cyc == 5)  m5  = mosi0;
      if (cyc == 10) m10 = mosi0;
      if (done0 === 1'b1) begin d = cyc; break; end
    end
    chk("lsb_mosi_bit0_c1", m1, 1'b1);
    chk("lsb_mosi_bit0_c5", m5, 1'b1);
    chk("lsb_mosi_bit1", m10, 1'b0);
    chk("lsb_done_cycle", d, 69);
    chk("lsb_rx", rx0, 8'h01);
    lsb0 = 1'b0;
`else
    m1 = 1'b0; m5 = 1'b0; m10 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
